// File: rtl/imem_responder.sv
// Instruction-memory responder: pipelined in-order fetch responses with
// backdoor program load, flush and a bounded number of outstanding requests.
module imem_responder #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned QDEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } resp_t;

    logic [31:0]   mem [MEM_WORDS];

    logic          ready_q;
    logic          accept;
    logic          pop;
    logic          req_bad;
    logic          load_bad;
    logic [AW-1:0] req_idx;
    logic [AW-1:0] load_idx;
    resp_t         in_resp;
    resp_t         push_resp;
    logic          push_v;

    resp_t         q_mem [QDEPTH];
    logic [PW-1:0] wr_ptr, wr_ptr_n;
    logic [PW-1:0] rd_ptr, rd_ptr_n;
    logic [CW-1:0] q_cnt, q_cnt_n;
    logic [CW-1:0] out_cnt, out_cnt_n;
    logic          valid_n;
    resp_t         head_n;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Ready is held low during a flush cycle so nothing slips in as the pipe empties
    assign req_ready = ready_q & ~flush;
    assign accept    = req_valid & req_ready;
    assign pop       = resp_valid & resp_ready;

    assign req_idx  = req_addr[AW+1:2];
    assign load_idx = load_addr[AW+1:2];
    assign req_bad  = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
    assign load_bad = (load_addr[1:0] != 2'b00) || (load_addr[31:AW+2] != '0);

    // Capture the word at acceptance; a same-edge load write is not yet visible
    always_comb begin
        in_resp.err  = req_bad;
        in_resp.data = req_bad ? NOP : mem[req_idx];
    end

    // Backdoor program load; memory is deliberately not reset
    always_ff @(posedge clk) begin
        if (load_en && !load_bad) begin
            mem[load_idx] <= load_data;
        end
    end

    // Delay line so the response enters the queue exactly LATENCY cycles after accept
    if (LATENCY == 1) begin : g_direct
        assign push_v    = accept;
        assign push_resp = in_resp;
    end else begin : g_pipe
        logic [LATENCY-2:0] pv;
        resp_t              pd [LATENCY-1];

        // Shift accepted requests toward the output queue
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pv <= '0;
                for (int unsigned i = 0; i < LATENCY - 1; i++) begin
                    pd[i] <= '0;
                end
            end else if (flush) begin
                pv <= '0;
            end else begin
                pv[0] <= accept;
                pd[0] <= in_resp;
                for (int unsigned i = 1; i < LATENCY - 1; i++) begin
                    pv[i] <= pv[i-1];
                    pd[i] <= pd[i-1];
                end
            end
        end

        assign push_v    = pv[LATENCY-2];
        assign push_resp = pd[LATENCY-2];
    end

    // Queue pointer, occupancy and next head computation
    always_comb begin
        wr_ptr_n  = wr_ptr;
        rd_ptr_n  = rd_ptr;
        q_cnt_n   = q_cnt;
        out_cnt_n = out_cnt;
        valid_n   = 1'b0;
        head_n    = '0;
        if (flush) begin
            wr_ptr_n  = '0;
            rd_ptr_n  = '0;
            q_cnt_n   = '0;
            out_cnt_n = '0;
        end else begin
            if (push_v) begin
                wr_ptr_n = ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr_n = ptr_inc(rd_ptr);
            end
            q_cnt_n   = q_cnt + CW'(push_v) - CW'(pop);
            out_cnt_n = out_cnt + CW'(accept) - CW'(pop);
            valid_n   = (q_cnt_n != '0);
            if (valid_n) begin
                // A push landing in the new head slot bypasses the storage read
                head_n = (push_v && (wr_ptr == rd_ptr_n)) ? push_resp : q_mem[rd_ptr_n];
            end
        end
    end

    // Queue storage write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                q_mem[i] <= '0;
            end
        end else if (push_v && !flush) begin
            q_mem[wr_ptr] <= push_resp;
        end
    end

    // Pointer/count state and registered response outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            q_cnt      <= '0;
            out_cnt    <= '0;
            ready_q    <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_n;
            rd_ptr     <= rd_ptr_n;
            q_cnt      <= q_cnt_n;
            out_cnt    <= out_cnt_n;
            ready_q    <= (out_cnt_n < CW'(QDEPTH));
            resp_valid <= valid_n;
            resp_data  <= head_n.data;
            resp_err   <= head_n.err;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder with a response scoreboard.
module tb_imem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    int          checks = 0;
    int          errors = 0;
    int          resp_count = 0;
    logic [32:0] sb [$];
    logic [31:0] model [1024];
    logic [31:0] stall_addrs [6];

    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic        prev_flush = 1'b0;
    logic [32:0] prev_resp  = '0;

    imem_responder #(
        .MEM_WORDS(1024),
        .LATENCY  (2),
        .QDEPTH   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .flush     (flush),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .resp_err  (resp_err),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] expect_of(input logic [31:0] a);
        if ((a[1:0] != 2'b00) || (a >= 32'h0000_1000)) begin
            return {1'b1, 32'h0000_0013};
        end
        return {1'b0, model[a[11:2]]};
    endfunction

    // Called just after a rising edge; returns one edge later
    task automatic load(input logic [31:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(posedge clk);
        #1;
        if ((a[1:0] == 2'b00) && (a < 32'h0000_1000)) begin
            model[a[11:2]] = d;
        end
        load_en = 1'b0;
    endtask

    // Present a request for one cycle; record expectation if it is taken
    task automatic issue(input logic [31:0] a, output logic acc);
        req_valid = 1'b1;
        req_addr  = a;
        @(negedge clk);
        acc = req_ready && !flush;
        if (acc) begin
            sb.push_back(expect_of(a));
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard pop on handshake plus hold-stability while stalled
    always @(negedge clk) begin
        if (rst && prev_valid && !prev_ready && !prev_flush) begin
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_data", resp_data, prev_resp[31:0]);
            check("hold_err", 32'(resp_err), 32'(prev_resp[32]));
        end
        if (rst && resp_valid && resp_ready) begin
            resp_count++;
            check("resp_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                logic [32:0] e;
                e = sb.pop_front();
                check("resp_data", resp_data, e[31:0]);
                check("resp_err", 32'(resp_err), 32'(e[32]));
            end
        end
        prev_valid = rst && resp_valid;
        prev_ready = resp_ready;
        prev_flush = flush;
        prev_resp  = {resp_err, resp_data};
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic acc;
        int   acc_n;
        int   rc0;

        stall_addrs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        flush      = 1'b0;
        resp_ready = 1'b0;
        load_en    = 1'b0;
        load_addr  = '0;
        load_data  = '0;

        #3;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", 32'(req_ready), 32'd1);

        // Program load
        load(32'h0000, 32'h0050_0093);
        load(32'h0004, 32'h00A0_0113);
        load(32'h0008, 32'h00F0_0193);
        load(32'h000C, 32'h0140_0213);
        load(32'h0010, 32'h1111_1111);
        load(32'h0014, 32'h2222_2222);
        load(32'h0FFC, 32'hCAFE_F00D);

        // Single fetch latency
        resp_ready = 1'b1;
        issue(32'h0, acc);
        req_valid = 1'b0;
        check("lat_accept", 32'(acc), 32'd1);
        @(negedge clk);
        check("lat_t1_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        check("lat_t2_valid", 32'(resp_valid), 32'd1);
        check("lat_t2_data", resp_data, 32'h0050_0093);
        check("lat_t2_err", 32'(resp_err), 32'd0);
        @(posedge clk);
        #1;

        // Back-to-back fetches
        rc0 = resp_count;
        for (int i = 0; i < 4; i++) begin
            issue(32'(i * 4), acc);
            check("b2b_ready", 32'(acc), 32'd1);
        end
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b_v_t4", 32'(resp_valid), 32'd1);
        @(negedge clk);
        check("b2b_v_t5", 32'(resp_valid), 32'd1);
        @(negedge clk);
        check("b2b_v_t6", 32'(resp_valid), 32'd0);
        check("b2b_count", 32'(resp_count - rc0), 32'd4);
        @(posedge clk);
        #1;

        // Misaligned, out-of-range and last-word boundary
        issue(32'h0000_0002, acc);
        issue(32'h0000_1000, acc);
        issue(32'h0000_0FFC, acc);
        issue(32'h0000_0003, acc);
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("err_drained", 32'(sb.size()), 32'd0);

        // Back-pressure up to the outstanding limit
        resp_ready = 1'b0;
        acc_n = 0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            req_addr  = stall_addrs[acc_n];
            @(negedge clk);
            if (!req_ready) break;
            sb.push_back(expect_of(req_addr));
            acc_n++;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("stall_accepts", 32'(acc_n), 32'd4);
        repeat (3) @(negedge clk);
        check("stall_ready_low", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("stall_drained", 32'(sb.size()), 32'd0);
        check("stall_ready_back", 32'(req_ready), 32'd1);

        // Same-cycle load and read of one word, then ignored bad loads
        load_en   = 1'b1;
        load_addr = 32'h10;
        load_data = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        req_addr  = 32'h10;
        @(negedge clk);
        check("wr_rd_accept", 32'(req_ready), 32'd1);
        sb.push_back(expect_of(32'h10));
        @(posedge clk);
        #1;
        model[4]  = 32'hDEAD_BEEF;
        load_en   = 1'b0;
        req_valid = 1'b0;
        issue(32'h10, acc);
        req_valid = 1'b0;
        load(32'h0000_0011, 32'h0BAD_BAD0);
        load(32'h0000_1010, 32'h0BAD_BAD1);
        issue(32'h10, acc);
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("load_drained", 32'(sb.size()), 32'd0);

        // Flush with two outstanding
        resp_ready = 1'b0;
        issue(32'h0, acc);
        issue(32'h4, acc);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'hC;
        @(negedge clk);
        check("flush_ready_low", 32'(req_ready), 32'd0);
        @(posedge clk);
        sb.delete();
        #1;
        flush      = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("flush_quiet", 32'(resp_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        issue(32'h8, acc);
        req_valid = 1'b0;
        check("post_flush_accept", 32'(acc), 32'd1);
        @(negedge clk);
        check("post_flush_t1", 32'(resp_valid), 32'd0);
        @(negedge clk);
        check("post_flush_t2", 32'(resp_valid), 32'd1);
        check("post_flush_data", resp_data, 32'h00F0_0193);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-stream
        resp_ready = 1'b0;
        issue(32'h0, acc);
        issue(32'h4, acc);
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", 32'(resp_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        check("mid_rst_data", resp_data, 32'd0);
        check("mid_rst_err", 32'(resp_err), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst2", 32'(req_ready), 32'd1);
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_quiet", 32'(resp_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Memory survives reset and flush
        issue(32'h10, acc);
        issue(32'hC, acc);
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("final_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
